// File: rtl/regbank_sb.sv
// Register bank with registered read ports, write forwarding,
// flush/hold of the read outputs and a pending-write scoreboard.
module regbank_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     hold,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr
);

    localparam int NREGS = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0]     regs_q [NREGS];
    logic [DATA_W-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NRD*DATA_W-1:0] rd_data_q;
    logic [NRD*DATA_W-1:0] rd_data_d;
    logic [NRD-1:0]        rd_busy_q;
    logic [NRD-1:0]        rd_busy_d;
    logic                  wr_ok;
    logic [ADDR_W-1:0]     ra;

    assign wr_ok = wr_en && !(ZR && (wr_addr == '0));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // A new issue follows the retiring write, so set overrides clear.
        if (busy_set) begin
            busy_d[busy_addr] = 1'b1;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        ra        = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (clear) begin
                rd_data_d[i*DATA_W +: DATA_W] = '0;
                rd_busy_d[i]                  = 1'b0;
            end else if (hold) begin
                rd_data_d[i*DATA_W +: DATA_W] = rd_data_q[i*DATA_W +: DATA_W];
                rd_busy_d[i]                  = rd_busy_q[i];
            end else if (ZR && (ra == '0)) begin
                rd_data_d[i*DATA_W +: DATA_W] = '0;
                rd_busy_d[i]                  = 1'b0;
            end else if (wr_en && (wr_addr == ra)) begin
                rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                rd_busy_d[i]                  = busy_d[ra];
            end else begin
                rd_data_d[i*DATA_W +: DATA_W] = regs_q[ra];
                rd_busy_d[i]                  = busy_d[ra];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= regs_d[n];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regbank_sb.sv
// Directed vector bench for regbank_sb: default instance plus a
// 16-bit / 8-register / 3-port / no-zero-register instance.
module tb_regbank_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hold, clear, wr_en, busy_set;
    logic [3:0]  wr_addr, busy_addr;
    logic [31:0] wr_data;

    logic [8:0]  p_rd_addr;
    logic [47:0] p_rd_data;
    logic [2:0]  p_rd_busy;
    logic        p_hold, p_clear, p_wr_en, p_busy_set;
    logic [2:0]  p_wr_addr, p_busy_addr;
    logic [15:0] p_wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_sb dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .hold(hold), .clear(clear), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
        .busy_addr(busy_addr)
    );

    regbank_sb #(.DATA_W(16), .ADDR_W(3), .NRD(3), .ZERO_REG(0)) dutp (
        .clk(clk), .reset(reset), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .rd_busy(p_rd_busy), .hold(p_hold), .clear(p_clear),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .busy_set(p_busy_set), .busy_addr(p_busy_addr)
    );

    typedef struct {
        logic [3:0]  a0, a1;
        logic        hold, clr, we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        bs;
        logic [3:0]  ba;
        logic [31:0] e0, e1;
        logic        eb0, eb1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(int a0, int a1, bit h, bit c, bit we,
                               int wa, logic [31:0] wd, bit bs, int ba,
                               logic [31:0] e0, logic [31:0] e1,
                               bit eb0, bit eb1);
        vec_t r;
        r.a0 = 4'(a0); r.a1 = 4'(a1); r.hold = h; r.clr = c;
        r.we = we; r.wa = 4'(wa); r.wd = wd; r.bs = bs; r.ba = 4'(ba);
        r.e0 = e0; r.e1 = e1; r.eb0 = eb0; r.eb1 = eb1;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        rd_addr   = {t.a1, t.a0};
        hold      = t.hold;
        clear     = t.clr;
        wr_en     = t.we;
        wr_addr   = t.wa;
        wr_data   = t.wd;
        busy_set  = t.bs;
        busy_addr = t.ba;
    endtask

    task automatic check_out(string tag, vec_t t);
        chk({tag, " d0"}, 64'(rd_data[31:0]), 64'(t.e0));
        chk({tag, " d1"}, 64'(rd_data[63:32]), 64'(t.e1));
        chk({tag, " b0"}, 64'(rd_busy[0]), 64'(t.eb0));
        chk({tag, " b1"}, 64'(rd_busy[1]), 64'(t.eb1));
    endtask

    initial begin
        vec_t t;
        reset = 1'b1;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        p_rd_addr = '0; p_hold = 0; p_clear = 0; p_wr_en = 0;
        p_wr_addr = '0; p_wr_data = '0; p_busy_set = 0; p_busy_addr = '0;

        repeat (2) @(negedge clk);
        chk("reset data", rd_data, 64'h0);
        chk("reset busy", 64'(rd_busy), 64'h0);
        reset = 1'b0;

        // Write + mark r5, then assert reset in the middle of a cycle.
        @(negedge clk);
        t = v(5, 5, 0, 0, 1, 5, 32'hDEADBEEF, 1, 5,
              32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
        drive(t);
        @(posedge clk); #1;
        check_out("pre-rst fwd", t);
        @(negedge clk);
        t = v(5, 5, 0, 0, 0, 0, 0, 0, 0,
              32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
        drive(t);
        @(posedge clk); #1;
        check_out("pre-rst read", t);
        #2 reset = 1'b1;
        #1;
        chk("async rst data", rd_data, 64'h0);
        chk("async rst busy", 64'(rd_busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        t = v(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        @(posedge clk); #1;
        check_out("post-rst r5", t);

        // a0 a1 hold clr we wa wd bs ba | e0 e1 eb0 eb1
        tv.push_back(v(1, 2, 0, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(3, 3, 0, 0, 0, 0, 0, 0, 0,
                       32'h12345678, 32'h12345678, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(7, 6, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0,
                       32'hA5A5A5A5, 0, 0, 0));
        tv.push_back(v(7, 7, 0, 0, 0, 0, 0, 0, 0,
                       32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0));
        tv.push_back(v(4, 4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 1));
        tv.push_back(v(4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1, 0));
        tv.push_back(v(4, 4, 0, 0, 1, 4, 32'hCAFE0004, 0, 0,
                       32'hCAFE0004, 32'hCAFE0004, 0, 0));
        tv.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 0,
                       32'hCAFE0004, 32'hCAFE0004, 0, 0));
        tv.push_back(v(4, 4, 0, 0, 1, 4, 32'hBEEF0004, 1, 4,
                       32'hBEEF0004, 32'hBEEF0004, 1, 1));
        tv.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 0,
                       32'hBEEF0004, 32'hBEEF0004, 1, 1));
        tv.push_back(v(4, 2, 0, 0, 1, 4, 32'h44, 0, 0, 32'h44, 0, 0, 0));
        tv.push_back(v(3, 3, 0, 0, 0, 0, 0, 0, 0,
                       32'h12345678, 32'h12345678, 0, 0));
        tv.push_back(v(7, 4, 1, 0, 1, 3, 32'h9, 0, 0,
                       32'h12345678, 32'h12345678, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0,
                       32'h12345678, 32'h12345678, 0, 0));
        tv.push_back(v(3, 3, 1, 0, 0, 0, 0, 0, 0,
                       32'h12345678, 32'h12345678, 0, 0));
        tv.push_back(v(3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(3, 3, 0, 0, 0, 0, 0, 0, 0, 32'h9, 32'h9, 0, 0));
        tv.push_back(v(5, 5, 1, 0, 0, 0, 0, 1, 5, 32'h9, 32'h9, 0, 0));
        tv.push_back(v(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(v(5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h9, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), tv[i]);
        end

        @(negedge clk);
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Parametrised instance: r0 is an ordinary register here.
        p_wr_en = 1; p_wr_addr = 3'd0; p_wr_data = 16'hBEEF;
        p_rd_addr = '0;
        @(posedge clk); #1;
        chk("p fwd r0", 64'(p_rd_data), {16'h0, {3{16'hBEEF}}});
        chk("p fwd busy", 64'(p_rd_busy), 64'h0);
        @(negedge clk);
        p_wr_en = 0; p_busy_set = 1; p_busy_addr = 3'd0;
        @(posedge clk); #1;
        chk("p read r0", 64'(p_rd_data), {16'h0, {3{16'hBEEF}}});
        chk("p busy set", 64'(p_rd_busy), 64'h7);
        @(negedge clk);
        p_busy_set = 0;
        p_rd_addr = {3'd0, 3'd1, 3'd0};
        @(posedge clk); #1;
        chk("p busy held", 64'(p_rd_busy), 64'h5);
        chk("p mixed data", 64'(p_rd_data), {16'h0, 16'hBEEF, 16'h0, 16'hBEEF});
        @(negedge clk);
        p_wr_en = 1; p_wr_data = 16'h1234;
        @(posedge clk); #1;
        chk("p wb data", 64'(p_rd_data), {16'h0, 16'h1234, 16'h0, 16'h1234});
        chk("p wb busy", 64'(p_rd_busy), 64'h0);
        @(negedge clk);
        p_wr_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_sb.md
# regbank_sb

Parametrised register bank with N registered read ports, one write port, write-to-read forwarding, per-bank clear/hold, and a per-register pending-write scoreboard. It is the CPU register file for the pipelined core: it sits between decode (read addresses, destination issue) and writeback (write port). Its `rd_busy` outputs let the hazard unit stall on registers whose write is still in flight.

## Interface

- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 4: register address width; the bank holds NREGS = 2^ADDR_W registers.
- `NRD`, default 2: number of read ports, legal range 1..4.
- `ZERO_REG`, default 1: when 1, register 0 reads as 0, ignores writes, and is never busy.

Ports:

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rd_addr` input NRD*ADDR_W: read addresses; port i is `[i*ADDR_W +: ADDR_W]`.
- `rd_data` output NRD*DATA_W: registered read data; port i is `[i*DATA_W +: DATA_W]`.
- `rd_busy` output NRD: registered scoreboard bit for each read address.
- `hold` input 1: freeze all read outputs.
- `clear` input 1: zero all read outputs (pipeline flush).
- `wr_en` input 1: write strobe.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `busy_set` input 1: mark a destination register as pending.
- `busy_addr` input ADDR_W: destination register to mark.

## Operation

- **Storage.** NREGS x DATA_W flops with asynchronous reset. RAM inference is not required.
- **Write.**
  - On an edge with `wr_en`=1, `regs[wr_addr]` <= `wr_data`.
  - The write is suppressed when ZERO_REG=1 and `wr_addr`=0.
  - `hold` and `clear` never block writes.
- **Scoreboard.** One busy bit per register, busy[n]. Next-state rules:
  - If `busy_set` and `busy_addr`=n: 1. Set wins over a same-cycle write, because the new issue follows the retiring write.
  - Else if `wr_en` and `wr_addr`=n: 0.
  - Else: hold.
  - With ZERO_REG=1, busy[0] is constantly 0.
- **Read port i, per edge, in priority order:**
  1. `clear`: `rd_data`[i]=0, `rd_busy`[i]=0.
  2. `hold`: both outputs keep their value.
  3. ZERO_REG=1 and addr=0: data 0, busy 0.
  4. `wr_en` and `wr_addr`=addr: data = `wr_data` (forwarded).
  5. Otherwise: data = `regs[addr]` (pre-edge value).
  - In cases 4 and 5, `rd_busy`[i] = next-state busy[addr]. A writeback forwarded in the same cycle therefore reads as not busy, unless `busy_set` re-marks that register.
- **Port independence.** All ports evaluate independently. Identical addresses on several ports return identical values.
- **Reset.** While `reset`=1:
  - all regs = 0;
  - all busy bits = 0;
  - `rd_data` = 0;
  - `rd_busy` = 0.
  - Reset asserted mid-operation aborts any pending write on that edge.

## Timing

- **Read latency:** 1 cycle. Address presented before edge k gives data valid after edge k.
- **Write latency:** visible to a non-forwarded read on the edge after the write edge. A read on the same edge as the write is covered by forwarding, so effective read-after-write latency is 0.
- **Scoreboard set latency:** `busy_set` at edge k makes `rd_busy` read 1 for a read issued at edge k. The reported value is the next-state value, so the 1 appears after edge k.
- **Hold and clear:**
  - `hold` has no effect on scoreboard or write state.
  - `clear`+`hold` together: `clear` wins.
- **Out-of-range addresses:** none are possible, since every address is full-width.
- **Combinational paths:** none from inputs to outputs. All outputs are flops.

## Test plan

- **Reset.** Assert `reset` asynchronously mid-cycle after writing r5=0xDEADBEEF, then read r5 -> `rd_data`=0 immediately, 0 after release, `rd_busy`=0.
- **Write, read, zero register.** Write r3=0x12345678, then next cycle read r3 on both ports -> both ports 0x12345678 one cycle later. Write r0=0xFFFFFFFF, read r0 -> 0.
- **Forwarding.** Same edge: `wr_en` r7=0xA5A5A5A5, port0 reads r7 while r7 holds 0x11 -> port0=0xA5A5A5A5. Port1 reading r6 is unaffected.
- **Scoreboard.**
  - `busy_set` r4, read r4 -> `rd_busy`=1 until writeback.
  - Writeback r4 with port0 reading r4 -> data forwarded and `rd_busy`=0.
  - Simultaneous `busy_set` r4 and write r4 -> `rd_busy`=1.
- **Hold and clear.**
  - Read r3 (0x12345678), then `hold` 3 cycles while changing the address and writing r3=0x9 -> output stays 0x12345678.
  - `clear`+`hold` -> outputs 0.
  - Release -> reads resume with 0x9.
- **Parametrisation.** DATA_W=16, ADDR_W=3, NRD=3, ZERO_REG=0: write r0=0xBEEF -> reads back 0xBEEF on all three ports, and `busy_set` r0 -> `rd_busy`=1.
